mux_reg_scan: RTL and testbench
===============================

# mux_reg_scan

Parametrised, registered N-to-1 multiplexer for the gate-delay cell library: the registered, multi-channel, multi-bit successor to the library's 2:1 mux and flip-flop cells. Each enabled cycle it captures one of CHANNELS input words into an output register. The channel comes either from an external select (manual mode) or from an internal round-robin scan pointer (auto mode). It also counts output bit transitions so that testbenches can estimate switching energy from PwrC.

## Interface
- WIDTH, 8: bits per channel word (≥1).
- CHANNELS, 4: number of input channels (≥2; need not be a power of two).
- CNT_W, 16: width of the toggle counter.
- PwrC, 0.00003: energy per output bit toggle; simulation-only, no synthesis effect.
- SEL_W (localparam): clog2(CHANNELS).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  capture enable.
- auto  input  1  1 = round-robin scan; 0 = use sel.
- sel  input  SEL_W  channel select, used only when auto=0.
- data  input  CHANNELS*WIDTH  flattened inputs; channel k = data[k*WIDTH +: WIDTH].
- clr_cnt  input  1  synchronous clear of the toggle counter.
- Q  output  WIDTH  registered selected word.
- ch  output  SEL_W  channel index whose word is in Q.
- valid  output  1  one-cycle strobe after each successful capture.
- toggles  output  CNT_W  saturating count of Q bit transitions.

## Operation
- Reset (async assert, sync-free release): Q=0, ch=0, valid=0, toggles=0, internal scan pointer ptr=0. Reset mid-scan discards ptr; scanning resumes at channel 0.
- Effective channel c: auto=1 → ptr; auto=0 → sel.
- en=1 and c < CHANNELS:
  - Q ← data[c], ch ← c, valid ← 1.
  - If auto=1, ptr ← (ptr == CHANNELS-1) ? 0 : ptr+1.
- en=1, auto=0 and sel ≥ CHANNELS (only possible for non-power-of-two CHANNELS): Q and ch hold, valid ← 0. Out-of-range is never latched.
- en=0: Q, ch and ptr hold, valid ← 0.
- ptr advances only when en=1 and auto=1. In manual mode it holds its value, so returning to auto resumes where the scan left off.
- Toggle counter, evaluated every cycle:
  - d = popcount(Q_next ^ Q).
  - toggles ← min(toggles + d, 2^CNT_W − 1).
- clr_cnt=1 wins over any increment in the same cycle: toggles ← 0 and that cycle's d is discarded.
- Saturation: once toggles reaches all-ones it stays there until clr_cnt or reset.
- Simulation-only energy estimate is toggles × PwrC. It is reported through a task, not a port.

## Timing
- Latency: data/sel sampled at edge N appear on Q/ch after edge N; valid is high during cycle N+1 only.
- Back-to-back en=1 gives one capture per cycle. Auto mode visits 0,1,…,CHANNELS−1,0,… with no idle cycle at wrap.
- toggles reflects a transition on the same edge that updates Q.
- All outputs change only on clk rising edge or reset assertion; no combinational input→output paths.

## Structure
- Shared include delay_lib_defs.vh:
  - default PwrC constant;
  - clog2 macro/function;
  - the channel-slice macro.
- Sub-module popcount_w (parameter WIDTH): purely combinational bit count, output width clog2(WIDTH+1), reused by future cells that need power accounting.
- Top-level blocks: scan pointer, output register, saturating counter.

## Test plan
All scenarios use WIDTH=8, CHANNELS=3, CNT_W=4, data = {8'hCC, 8'hF0, 8'h0F} (ch2..ch0).
- Reset, then manual sel=1, en=1 for one cycle: Q=8'hF0, ch=1, valid pulses once, toggles=4.
- Auto=1, en=1 held 5 cycles after reset: ch sequence 0,1,2,0,1 and Q sequence 0F,F0,CC,0F,F0; valid high all 5 cycles; toggles counts 4,12 then saturates at 15.
- Manual sel=3 (out of range) with Q=8'h0F: Q stays 8'h0F, ch=0, valid=0, toggles unchanged.
- clr_cnt=1 on the same edge as a capture changing Q 0F→F0: toggles=0 afterwards; the next identical capture gives toggles=0 (no transitions).
- Async reset asserted mid-cycle during an auto scan at ptr=2: Q=0, ch=0, valid=0, toggles=0 immediately, without a clock edge; after release the first auto capture takes channel 0.
- Auto scan reaches ptr=1, switch to manual (sel=2) for 2 cycles, then back to auto: Q=CC twice, then the auto capture takes channel 1.

Source files
------------

// File: rtl/mux_reg_scan_pkg.sv
// Shared definitions for the registered scan multiplexer and its power-accounting helpers.
package mux_reg_scan_pkg;

  localparam real PWRC_DEFAULT = 0.00003;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Ceiling log2 for sizing index and count fields; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < n) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount_w.sv
// Purely combinational population count; the output is just wide enough to hold WIDTH.
module popcount_w
  import mux_reg_scan_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/mux_reg_scan.sv
// Registered N-to-1 multiplexer with manual select or round-robin scan, plus a
// saturating count of output bit toggles for switching-energy estimates.
module mux_reg_scan
  import mux_reg_scan_pkg::*;
#(
  parameter  int  WIDTH    = 8,
  parameter  int  CHANNELS = 4,
  parameter  int  CNT_W    = 16,
  parameter  real PwrC     = PWRC_DEFAULT,
  localparam int  SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      auto,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic                      clr_cnt,
  output logic [WIDTH-1:0]          Q,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic [CNT_W-1:0]          toggles
);

  localparam int PC_W  = clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SEL_W:0]     NCH  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0]   LAST = SEL_W'(CHANNELS - 1);
  localparam logic [SUM_W-1:0]   SAT  = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  mode_e            mode_s;
  logic [SEL_W-1:0] c_s;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic             hit_s;
  logic             valid_q, valid_d;
  logic [PC_W-1:0]  flips_s;
  logic [SUM_W-1:0] sum_s;
  logic [CNT_W-1:0] tog_q, tog_d;

  // Scan pointer and effective channel; the pointer only moves on enabled auto cycles.
  always_comb begin
    mode_s = mode_e'(auto);
    case (mode_s)
      MODE_AUTO:   c_s = ptr_q;
      MODE_MANUAL: c_s = sel;
      default:     c_s = sel;
    endcase
    if (en && (mode_s == MODE_AUTO)) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + SEL_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Output register next state; an out-of-range manual select matches no channel and is never latched.
  always_comb begin
    word_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      word_s = (c_s == SEL_W'(k)) ? data[k*WIDTH +: WIDTH] : word_s;
    end
    hit_s = en && ({1'b0, c_s} < NCH);
    if (hit_s) begin
      q_d     = word_s;
      ch_d    = c_s;
      valid_d = 1'b1;
    end else begin
      q_d     = q_q;
      ch_d    = ch_q;
      valid_d = 1'b0;
    end
  end

  popcount_w #(.WIDTH(WIDTH)) u_flips (
    .vec_i (q_d ^ q_q),
    .cnt_o (flips_s)
  );

  // Saturating toggle counter; the sum is one bit wider so overflow is visible before clamping.
  always_comb begin
    sum_s = SUM_W'(tog_q) + SUM_W'(flips_s);
    if (clr_cnt) begin
      tog_d = '0;
    end else if (sum_s > SAT) begin
      tog_d = '1;
    end else begin
      tog_d = sum_s[CNT_W-1:0];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      q_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      tog_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      tog_q   <= tog_d;
    end
  end

  assign Q       = q_q;
  assign ch      = ch_q;
  assign valid   = valid_q;
  assign toggles = tog_q;

  // Simulation-side energy estimate for the transitions counted so far.
  task automatic report_energy(output real energy);
    energy = real'(tog_q) * PwrC;
  endtask

endmodule

// File: tb/tb_mux_reg_scan.sv
// Table-driven bench for mux_reg_scan (WIDTH=8, CHANNELS=3, CNT_W=4) with a queue of expected results.
module tb_mux_reg_scan;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       am;
    logic [1:0] sel;
    logic       clr;
    logic [7:0] q;
    logic [1:0] ch;
    logic       v;
    logic [3:0] t;
  } vec_t;

  typedef struct packed {
    logic [7:0] q;
    logic [1:0] ch;
    logic       v;
    logic [3:0] t;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        en;
  logic        auto_m;
  logic [1:0]  sel;
  logic [23:0] data;
  logic        clr_cnt;
  logic [7:0]  q_o;
  logic [1:0]  ch_o;
  logic        valid_o;
  logic [3:0]  tog_o;

  int   n_vec;
  int   n_err;
  exp_t exp_q[$];
  vec_t tbl[22];

  mux_reg_scan #(.WIDTH(8), .CHANNELS(3), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .auto    (auto_m),
    .sel     (sel),
    .data    (data),
    .clr_cnt (clr_cnt),
    .Q       (q_o),
    .ch      (ch_o),
    .valid   (valid_o),
    .toggles (tog_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic r, input logic e, input logic a, input logic [1:0] s,
                              input logic c, input logic [7:0] q, input logic [1:0] h,
                              input logic v, input logic [3:0] t);
    vec_t x;
    x.rst = r; x.en = e; x.am = a; x.sel = s; x.clr = c;
    x.q = q; x.ch = h; x.v = v; x.t = t;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".Q"},       32'(q_o),     32'(e.q));
    chk({tag, ".ch"},      32'(ch_o),    32'(e.ch));
    chk({tag, ".valid"},   32'(valid_o), 32'(e.v));
    chk({tag, ".toggles"}, 32'(tog_o),   32'(e.t));
  endtask

  // Reset asserted between edges; outputs must clear without any clock edge.
  task automatic reset_dut();
    exp_t z;
    z = '0;
    @(negedge clk);
    en = 1'b0; clr_cnt = 1'b0; reset = 1'b1;
    #1;
    n_vec++;
    chk_all("reset", z);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t x, input string tag);
    exp_t e;
    @(negedge clk);
    en = x.en; auto_m = x.am; sel = x.sel; clr_cnt = x.clr;
    e.q = x.q; e.ch = x.ch; e.v = x.v; e.t = x.t;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      chk_all(tag, exp_q.pop_front());
    end
  endtask

  initial begin
    exp_t z;
    z = '0;
    n_vec = 0; n_err = 0;
    reset = 1'b1; en = 1'b0; auto_m = 1'b0; sel = 2'd0; clr_cnt = 1'b0;
    data = {8'hCC, 8'hF0, 8'h0F};

    // manual capture, hold, out-of-range select, clear-on-capture, saturation
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'hF0, 2'd1, 1'b1, 4'd4);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'hF0, 2'd1, 1'b0, 4'd4);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h0F, 2'd0, 1'b1, 4'd12);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 8'h0F, 2'd0, 1'b0, 4'd12);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 8'hF0, 2'd1, 1'b1, 4'd0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'hF0, 2'd1, 1'b1, 4'd0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h0F, 2'd0, 1'b1, 4'd8);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'hF0, 2'd1, 1'b1, 4'd15);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 8'hCC, 2'd2, 1'b1, 4'd15);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'hCC, 2'd2, 1'b0, 4'd15);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'hCC, 2'd2, 1'b0, 4'd0);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h0F, 2'd0, 1'b1, 4'd4);
    // auto scan from reset with wrap and no idle cycle
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'h0F, 2'd0, 1'b1, 4'd4);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 8'hF0, 2'd1, 1'b1, 4'd12);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'hCC, 2'd2, 1'b1, 4'd15);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 8'h0F, 2'd0, 1'b1, 4'd15);
    tbl[16] = mk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'hF0, 2'd1, 1'b1, 4'd15);
    // manual interlude keeps the scan pointer
    tbl[17] = mk(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h0F, 2'd0, 1'b1, 4'd4);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 8'hCC, 2'd2, 1'b1, 4'd8);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 8'hCC, 2'd2, 1'b1, 4'd8);
    tbl[20] = mk(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 8'hF0, 2'd1, 1'b1, 4'd12);
    tbl[21] = mk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'hCC, 2'd2, 1'b1, 4'd15);

    #12;
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].rst) reset_dut();
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a cycle while the scan pointer sits at 2.
    reset_dut();
    apply(mk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h0F, 2'd0, 1'b1, 4'd4), "mid.s0");
    apply(mk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'hF0, 2'd1, 1'b1, 4'd12), "mid.s1");
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    chk_all("mid.async", z);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    apply(mk(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h0F, 2'd0, 1'b1, 4'd4), "mid.after");
    apply(mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'h0F, 2'd0, 1'b0, 4'd4), "mid.idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
